// File: rtl/param_shift_reg.sv
// ============================================================================
//  Module      : param_shift_reg
//  Description : Command-driven parallel-load / shift / rotate register.
//                A command (LOAD, CLEAR, ASR, LSR, SHL, ROR, ROL, NOP) is
//                accepted when start=1 and the block is not busy. Shift and
//                rotate commands run one bit per clock for amt cycles, then
//                pulse done for one cycle.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous, active-high reset
//                start    - command strobe
//                op       - command code
//                d        - parallel load data (used at acceptance only)
//                amt      - shift/rotate step count
//                ser_in   - serial fill bit for LSR/SHL (sampled each step)
//                q        - register contents
//                ser_out  - last bit shifted or rotated out
//                busy     - high while a multi-cycle shift is running
//                done     - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] amt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  // Command codes
  localparam logic [2:0] c_op_load  = 3'b000;
  localparam logic [2:0] c_op_clear = 3'b001;
  localparam logic [2:0] c_op_asr   = 3'b010;
  localparam logic [2:0] c_op_lsr   = 3'b011;
  localparam logic [2:0] c_op_shl   = 3'b100;
  localparam logic [2:0] c_op_ror   = 3'b101;
  localparam logic [2:0] c_op_rol   = 3'b110;
  localparam logic [2:0] c_op_nop   = 3'b111;

  // FSM encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;

  logic             w_accept;
  logic             w_step_so;
  logic [WIDTH-1:0] w_step_q;

  // Commands are only taken when no shift is in flight; a start during
  // SHIFT is dropped entirely.
  assign w_accept = start && (r_state != c_st_shift);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (w_accept) begin
          case (op)
            c_op_load, c_op_clear: w_next_state = c_st_done;
            c_op_nop:              w_next_state = c_st_idle;
            default: begin
              // Zero-length shifts complete immediately without stepping.
              if (amt == c_cnt_zero) begin
                w_next_state = c_st_done;
              end else begin
                w_next_state = c_st_shift;
              end
            end
          endcase
        end else begin
          w_next_state = c_st_idle;
        end
      end
      c_st_shift: begin
        if (r_cnt == c_cnt_one) begin
          w_next_state = c_st_done;
        end else begin
          w_next_state = c_st_shift;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register, hence glitch-free)
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_st_shift: busy = 1'b1;
      c_st_done:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-bit step for the latched operation
  // --------------------------------------------------------------------------
  always_comb begin
    w_step_q  = r_q;
    w_step_so = r_ser_out;
    case (r_op)
      c_op_asr: begin
        w_step_q  = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_step_so = r_q[0];
      end
      c_op_lsr: begin
        w_step_q  = {ser_in, r_q[WIDTH-1:1]};
        w_step_so = r_q[0];
      end
      c_op_shl: begin
        w_step_q  = {r_q[WIDTH-2:0], ser_in};
        w_step_so = r_q[WIDTH-1];
      end
      c_op_ror: begin
        w_step_q  = {r_q[0], r_q[WIDTH-1:1]};
        w_step_so = r_q[0];
      end
      c_op_rol: begin
        w_step_q  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_step_so = r_q[WIDTH-1];
      end
      default: begin
        w_step_q  = r_q;
        w_step_so = r_ser_out;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_ser_out <= 1'b0;
      r_cnt     <= '0;
      r_op      <= c_op_nop;
    end else if (w_accept) begin
      case (op)
        c_op_load: begin
          r_q       <= d;
          r_ser_out <= 1'b0;
        end
        c_op_clear: begin
          r_q       <= '0;
          r_ser_out <= 1'b0;
        end
        c_op_nop: begin
          r_q       <= r_q;
        end
        default: begin
          // No step on the acceptance edge; the count runs in SHIFT.
          r_op  <= op;
          r_cnt <= amt;
        end
      endcase
    end else if (r_state == c_st_shift) begin
      r_q       <= w_step_q;
      r_ser_out <= w_step_so;
      r_cnt     <= r_cnt - c_cnt_one;
    end
  end

  assign q       = r_q;
  assign ser_out = r_ser_out;

endmodule

`default_nettype wire

// File: tb/tb_param_shift_reg.sv
// ============================================================================
//  Module      : tb_param_shift_reg
//  Description : Self-checking bench for param_shift_reg (WIDTH=8, CNT_W=4).
//                Table vectors, hand-written corner sequences and random
//                commands compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] c_load  = 3'd0;
  localparam logic [2:0] c_clear = 3'd1;
  localparam logic [2:0] c_asr   = 3'd2;
  localparam logic [2:0] c_lsr   = 3'd3;
  localparam logic [2:0] c_shl   = 3'd4;
  localparam logic [2:0] c_ror   = 3'd5;
  localparam logic [2:0] c_rol   = 3'd6;
  localparam logic [2:0] c_nop   = 3'd7;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] amt;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  param_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .d       (d),
    .amt     (amt),
    .ser_in  (ser_in),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: final register value, serial out and done latency of a
  // whole command, computed with wide-vector arithmetic (ser_in held constant).
  function automatic void model(input logic [2:0] m_op, input int n,
                                input logic [7:0] q0, input logic so0,
                                input logic [7:0] dd, input logic si,
                                output logic [7:0] qf, output logic sof,
                                output int lat);
    logic [22:0] v;
    logic [22:0] w;
    logic [15:0] dq;
    int          k;
    qf  = q0;
    sof = so0;
    lat = 1;
    k   = n % 8;
    case (m_op)
      c_load:  begin qf = dd; sof = 1'b0; end
      c_clear: begin qf = '0; sof = 1'b0; end
      c_nop:   lat = 0;
      default: begin
        if (n > 0) begin
          lat = n + 1;
          case (m_op)
            c_asr, c_lsr: begin
              v   = {{15{(m_op == c_asr) ? q0[7] : si}}, q0};
              w   = v >> n;
              qf  = w[7:0];
              sof = v[n-1];
            end
            c_shl: begin
              v   = {q0, {15{si}}};
              w   = v << n;
              qf  = w[22:15];
              sof = v[23-n];
            end
            c_ror: begin
              dq  = {q0, q0} >> k;
              qf  = dq[7:0];
              sof = qf[7];
            end
            default: begin
              dq  = {q0, q0} << k;
              qf  = dq[15:8];
              sof = qf[0];
            end
          endcase
        end
      end
    endcase
  endfunction

  // Called at a negedge. Issues a command, then watches each following
  // negedge until done. lat = cycle count from acceptance to done (-1 on
  // timeout). With noise set, start is held high with a LOAD of 0xFF during
  // every busy cycle; those strobes must be ignored.
  task automatic run_cmd(input logic [2:0] c_op, input logic [3:0] c_amt,
                         input logic [7:0] c_d, input logic c_si, input bit noise,
                         output int lat, output int busy_cycles);
    start  = 1'b1;
    op     = c_op;
    amt    = c_amt;
    d      = c_d;
    ser_in = c_si;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (noise) begin
        start = 1'b1;
        op    = c_load;
        d     = 8'hFF;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) lat = -1;
  endtask

  // Runs a command to completion and steps one further cycle, checking that
  // done was a single-cycle pulse.
  task automatic run_full(input string name, input logic [2:0] c_op, input logic [3:0] c_amt,
                          input logic [7:0] c_d, input logic c_si, input bit noise,
                          output int lat, output int busy_cycles,
                          output logic [7:0] q_at_done, output logic so_at_done);
    run_cmd(c_op, c_amt, c_d, c_si, noise, lat, busy_cycles);
    q_at_done  = q;
    so_at_done = ser_out;
    @(negedge clk);
    chk({name, " done_width"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic preload(input logic [7:0] v);
    int l, b;
    logic [7:0] qq;
    logic so;
    run_full("preload", c_load, 4'd0, v, 1'b0, 1'b0, l, b, qq, so);
  endtask

  typedef struct {
    string      name;
    logic [7:0] pre;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       si;
    bit         noise;
    logic [7:0] exp_q;
    logic       exp_so;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int         lat, bc, nlat;
    logic [7:0] qd, eq;
    logic       sod, eso;
    logic [7:0] pre, rd;
    logic [2:0] rop;
    logic [3:0] ramt;
    logic       rsi;
    int         seen;

    checks = 0;
    errors = 0;
    start  = 1'b0;
    op     = c_nop;
    d      = '0;
    amt    = '0;
    ser_in = 1'b0;
    reset  = 1'b1;

    vecs[0] = '{"load_a5",   8'h00, c_load,  4'd0,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[1] = '{"asr3",      8'h96, c_asr,   4'd3,  8'h00, 1'b0, 1'b0, 8'hF2, 1'b1, 4};
    vecs[2] = '{"rol4",      8'h3C, c_rol,   4'd4,  8'h00, 1'b0, 1'b0, 8'hC3, 1'b1, 5};
    vecs[3] = '{"lsr2",      8'h00, c_lsr,   4'd2,  8'h00, 1'b1, 1'b0, 8'hC0, 1'b0, 3};
    vecs[4] = '{"shl12",     8'h81, c_shl,   4'd12, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 13};
    vecs[5] = '{"asr0",      8'h5A, c_asr,   4'd0,  8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1};
    vecs[6] = '{"clear",     8'hFF, c_clear, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1};
    vecs[7] = '{"ror9",      8'h01, c_ror,   4'd9,  8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 10};
    vecs[8] = '{"asr15",     8'h80, c_asr,   4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 16};
    vecs[9] = '{"shl1_fill", 8'hAA, c_shl,   4'd1,  8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 2};

    // Reset state, observed before any clock edge.
    #2;
    chk("reset_q", {24'd0, q}, 32'd0);
    chk("reset_flags", {29'd0, ser_out, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_flags", {29'd0, ser_out, busy, done}, 32'd0);

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].pre);
      run_full(vecs[i].name, vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].si,
               vecs[i].noise, lat, bc, qd, sod);
      chk({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, " busy_cycles"}, bc, vecs[i].exp_lat - 1);
      chk({vecs[i].name, " q"}, {24'd0, qd}, {24'd0, vecs[i].exp_q});
      chk({vecs[i].name, " ser_out"}, {31'd0, sod}, {31'd0, vecs[i].exp_so});
      chk({vecs[i].name, " q_hold"}, {24'd0, q}, {24'd0, vecs[i].exp_q});
    end

    // Back-to-back: new LOAD accepted during the DONE cycle of ASR amt=0.
    preload(8'h5A);
    run_cmd(c_asr, 4'd0, 8'h00, 1'b0, 1'b0, lat, bc);
    chk("b2b first latency", lat, 1);
    chk("b2b first q", {24'd0, q}, 32'h5A);
    start = 1'b1; op = c_load; d = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    chk("b2b second done", {31'd0, done}, 32'd1);
    chk("b2b second q", {24'd0, q}, 32'h3C);
    @(negedge clk);
    chk("b2b done_width", {30'd0, busy, done}, 32'd0);

    // NOP issued in the DONE cycle: no pulse, state returns to IDLE.
    run_cmd(c_asr, 4'd0, 8'h00, 1'b0, 1'b0, lat, bc);
    start = 1'b1; op = c_nop; d = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    chk("nop flags", {30'd0, busy, done}, 32'd0);
    chk("nop q", {24'd0, q}, 32'h3C);

    // Reset two steps into ROR amt=5: immediate clear, no later done pulse.
    preload(8'h0F);
    start = 1'b1; op = c_ror; amt = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ror_mid q", {24'd0, q}, 32'hC3);
    chk("ror_mid busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset q", {24'd0, q}, 32'd0);
    chk("async_reset flags", {29'd0, ser_out, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("post_reset no_done", seen, 0);
    run_full("post_reset load", c_load, 4'd0, 8'h77, 1'b0, 1'b0, lat, bc, qd, sod);
    chk("post_reset latency", lat, 1);
    chk("post_reset q", {24'd0, qd}, 32'h77);

    // Randomised commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      pre  = 8'($urandom);
      rd   = 8'($urandom);
      rop  = 3'($urandom_range(0, 7));
      ramt = 4'($urandom_range(0, 15));
      rsi  = 1'($urandom);
      preload(pre);
      model(rop, int'(ramt), pre, 1'b0, rd, rsi, eq, eso, nlat);
      if (rop == c_nop) begin
        start = 1'b1; op = rop; amt = ramt; d = rd; ser_in = rsi;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
          if (done || busy) seen++;
          @(negedge clk);
        end
        chk("rand nop flags", seen, 0);
        chk("rand nop q", {24'd0, q}, {24'd0, eq});
      end else begin
        run_full("rand", rop, ramt, rd, rsi, 1'($urandom), lat, bc, qd, sod);
        chk("rand latency", lat, nlat);
        chk("rand q", {24'd0, qd}, {24'd0, eq});
        chk("rand ser_out", {31'd0, sod}, {31'd0, eso});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
